// File: rtl/mont_pkg.sv
// rtl/mont_pkg.sv - state encoding and slice sizing shared by the Montgomery multiplier
package mont_pkg;

   typedef enum logic [2:0] {IDLE, PRE, LOOP_SEL, LOOP_ADD, SUB, DONE} state_e;

   // Slices needed to cover the WIDTH+2 bit accumulator
   function automatic int ns(input int width, input int add_w);
      return (width + 2 + add_w - 1) / add_w;
   endfunction

endpackage

// File: rtl/mont_slice_addsub.sv
// rtl/mont_slice_addsub.sv - one ADD_W-bit add/subtract slice with a registered carry/borrow
module mont_slice_addsub #(
   parameter int ADD_W = 128
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             clr,
   input  logic             en,
   input  logic             sub,
   input  logic [ADD_W-1:0] x,
   input  logic [ADD_W-1:0] y,
   output logic [ADD_W-1:0] sum,
   output logic             cout
);

   logic             cy_q;
   logic             cin;
   logic [ADD_W-1:0] y_eff;
   logic [ADD_W:0]   total;

   // Subtraction is x + ~y + 1; clr marks the LSB slice and injects the initial carry
   assign cin   = clr ? sub : cy_q;
   assign y_eff = sub ? ~y : y;
   assign total = {1'b0, x} + {1'b0, y_eff} + {{ADD_W{1'b0}}, cin};
   assign sum   = total[ADD_W-1:0];
   assign cout  = total[ADD_W];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cy_q <= 1'b0;
      end else if (en) begin
         cy_q <= cout;
      end
   end

endmodule

// File: rtl/montgomery_mult_sliced.sv
// rtl/montgomery_mult_sliced.sv - radix-2 Montgomery multiplier R = A*B*2^-WIDTH mod M with a sliced adder
module montgomery_mult_sliced
   import mont_pkg::*;
#(
   parameter int WIDTH     = 512,
   parameter int ADD_W     = 128,
   parameter int SKIP_ZERO = 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [WIDTH-1:0] in_m,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int NS  = ns(WIDTH, ADD_W);
   localparam int CW  = WIDTH + 2;
   localparam int PW  = NS * ADD_W;
   localparam int SW  = $clog2(NS + 1);
   localparam int SIW = $clog2(NS);
   localparam int IW  = $clog2(WIDTH);
   localparam logic [PW-1:0] C_MASK = ~({PW{1'b1}} << CW);

   typedef logic [NS-1:0][ADD_W-1:0] wide_t;

   state_e           state_q, state_d;
   logic [SW-1:0]    s_q, s_d;
   logic [IW-1:0]    i_q, i_d;
   logic [1:0]       sel_q, sel_d;
   logic [WIDTH-1:0] a_q, a_d;
   wide_t            b_q, b_d, m_q, m_d, bm_q, bm_d, c_q, c_d, d_q, d_d;
   logic [WIDTH-1:0] res_q, res_d;

   logic             en_s, sub_s, clr_s, cout_s;
   logic [ADD_W-1:0] x_s, y_s, sum_s, addend;
   logic [SIW-1:0]   sidx;
   logic             last_slice, last_iter;
   logic [1:0]       sel_now;
   logic [PW-1:0]    c_flat, c_new_flat, d_new_flat;
   wide_t            c_new, d_new;

   assign sidx       = s_q[SIW-1:0];
   assign clr_s      = (s_q == '0);
   assign last_slice = (s_q == SW'(NS - 1));
   assign last_iter  = (i_q == IW'(WIDTH - 1));
   assign c_flat     = c_q;
   // {a, q}: a is the multiplier bit, q makes C + a*B + q*M even
   assign sel_now    = {a_q[i_q], c_q[0][0] ^ (a_q[i_q] & b_q[0][0])};

   assign busy   = (state_q != IDLE);
   assign done   = (state_q == DONE);
   assign result = res_q;

   mont_slice_addsub #(.ADD_W(ADD_W)) u_slice (
      .clk    (clk),
      .resetn (resetn),
      .clr    (clr_s),
      .en     (en_s),
      .sub    (sub_s),
      .x      (x_s),
      .y      (y_s),
      .sum    (sum_s),
      .cout   (cout_s)
   );

   always_comb begin
      state_d    = state_q;
      s_d        = s_q;
      i_d        = i_q;
      sel_d      = sel_q;
      a_d        = a_q;
      b_d        = b_q;
      m_d        = m_q;
      bm_d       = bm_q;
      c_d        = c_q;
      d_d        = d_q;
      res_d      = res_q;
      en_s       = 1'b0;
      sub_s      = 1'b0;
      x_s        = '0;
      y_s        = '0;
      c_new      = c_q;
      d_new      = d_q;
      c_new_flat = '0;
      d_new_flat = '0;

      case (sel_q)
         2'b10:   addend = b_q[sidx];
         2'b01:   addend = m_q[sidx];
         2'b11:   addend = bm_q[sidx];
         default: addend = '0;
      endcase

      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = in_a;
               b_d     = PW'(in_b);
               m_d     = PW'(in_m);
               s_d     = '0;
               state_d = PRE;
            end
         end
         PRE: begin
            en_s       = 1'b1;
            x_s        = b_q[sidx];
            y_s        = m_q[sidx];
            bm_d[sidx] = sum_s;
            if (last_slice) begin
               s_d     = '0;
               c_d     = '0;
               i_d     = '0;
               state_d = LOOP_SEL;
            end else begin
               s_d = s_q + SW'(1);
            end
         end
         LOOP_SEL: begin
            if (sel_now == 2'b00 && SKIP_ZERO != 0) begin
               c_d = (c_flat >> 1) & C_MASK;
               i_d = i_q + IW'(1);
               if (last_iter) begin
                  state_d = SUB;
               end
            end else begin
               sel_d   = sel_now;
               state_d = LOOP_ADD;
            end
         end
         LOOP_ADD: begin
            en_s        = 1'b1;
            x_s         = c_q[sidx];
            y_s         = addend;
            c_new[sidx] = sum_s;
            c_new_flat  = c_new;
            if (last_slice) begin
               // The halving shift is folded into the last slice cycle
               c_d     = (c_new_flat >> 1) & C_MASK;
               i_d     = i_q + IW'(1);
               s_d     = '0;
               state_d = last_iter ? SUB : LOOP_SEL;
            end else begin
               c_d = c_new;
               s_d = s_q + SW'(1);
            end
         end
         SUB: begin
            en_s        = 1'b1;
            sub_s       = 1'b1;
            x_s         = c_q[sidx];
            y_s         = m_q[sidx];
            d_new[sidx] = sum_s;
            d_new_flat  = d_new;
            d_d         = d_new;
            if (last_slice) begin
               // Carry out of the top slice set means no borrow, i.e. C >= M
               res_d   = cout_s ? d_new_flat[WIDTH-1:0] : c_flat[WIDTH-1:0];
               s_d     = '0;
               state_d = DONE;
            end else begin
               s_d = s_q + SW'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         s_q     <= '0;
         i_q     <= '0;
         sel_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         m_q     <= '0;
         bm_q    <= '0;
         c_q     <= '0;
         d_q     <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         i_q     <= i_d;
         sel_q   <= sel_d;
         a_q     <= a_d;
         b_q     <= b_d;
         m_q     <= m_d;
         bm_q    <= bm_d;
         c_q     <= c_d;
         d_q     <= d_d;
         res_q   <= res_d;
      end
   end

endmodule

// File: tb/tb_montgomery_mult_sliced.sv
// tb/tb_montgomery_mult_sliced.sv - scoreboard bench for two 8-bit multipliers, with and without zero skipping
module tb_montgomery_mult_sliced;

   localparam int W  = 8;
   localparam int AW = 4;
   localparam int NS = 3;

   logic         clk = 1'b0;
   logic         resetn = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] in_a = '0, in_b = '0, in_m = '0;
   logic         busy1, done1, busy0, done0;
   logic [W-1:0] res1, res0;

   typedef struct {
      int res;
      int lat;
      bit chk_res;
   } exp_t;

   exp_t q1[$];
   exp_t q0[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   acc1 = 0, acc0 = 0;
   bit   prev_done1 = 0, prev_done0 = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   montgomery_mult_sliced #(.WIDTH(W), .ADD_W(AW), .SKIP_ZERO(1)) dut1 (
      .clk(clk), .resetn(resetn), .start(start), .in_a(in_a), .in_b(in_b), .in_m(in_m),
      .busy(busy1), .done(done1), .result(res1));

   montgomery_mult_sliced #(.WIDTH(W), .ADD_W(AW), .SKIP_ZERO(0)) dut0 (
      .clk(clk), .resetn(resetn), .start(start), .in_a(in_a), .in_b(in_b), .in_m(in_m),
      .busy(busy0), .done(done0), .result(res0));

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   // Result by definition: the unique r < M with r * 2^W == A*B (mod M)
   function automatic int mont_ref(input int a, input int b, input int m);
      int ab = (a * b) % m;
      for (int r = 0; r < m; r++) begin
         if (((r << W) % m) == ab) return r;
      end
      return 0;
   endfunction

   // Latency from the bit-serial algorithm: an iteration is free only if a = q = 0
   function automatic int lat_ref(input int a, input int b, input int m, input bit skip);
      int c = 0;
      int n = 0;
      for (int i = 0; i < W; i++) begin
         int ai = (a >> i) & 1;
         int q  = (c + ai * b) & 1;
         n += (skip && ai == 0 && q == 0) ? 1 : NS + 1;
         c = (c + ai * b + q * m) / 2;
      end
      return 2 * NS + n + 1;
   endfunction

   always @(negedge clk) begin : mon1
      exp_t e;
      if (resetn) begin
         if (done1) begin
            check("dut1 single done pulse", int'(prev_done1), 0);
            if (q1.size() == 0) begin
               check("dut1 unexpected done", 1, 0);
            end else begin
               e = q1.pop_front();
               if (e.chk_res) check("dut1 result", int'(res1), e.res);
               check("dut1 latency", cyc - acc1 + 1, e.lat);
            end
         end
         if (start && !busy1) acc1 = cyc + 1;
      end
      prev_done1 = done1;
   end

   always @(negedge clk) begin : mon0
      exp_t e;
      if (resetn) begin
         if (done0) begin
            check("dut0 single done pulse", int'(prev_done0), 0);
            if (q0.size() == 0) begin
               check("dut0 unexpected done", 1, 0);
            end else begin
               e = q0.pop_front();
               if (e.chk_res) check("dut0 result", int'(res0), e.res);
               check("dut0 latency", cyc - acc0 + 1, e.lat);
            end
         end
         if (start && !busy0) acc0 = cyc + 1;
      end
      prev_done0 = done0;
   end

   task automatic wait_idle();
      int t = 0;
      while ((busy1 || busy0) && t < 300) begin
         @(posedge clk); #1;
         t++;
      end
      if (busy1 || busy0) check("idle timeout", 1, 0);
   endtask

   // Issue one job; intrude > 0 pulses a second, different start that many cycles later
   task automatic run_job(input int a, input int b, input int m, input bit chk, input int intrude);
      exp_t e;
      wait_idle();
      in_a  = W'(a);
      in_b  = W'(b);
      in_m  = W'(m);
      start = 1'b1;
      e.res = chk ? mont_ref(a, b, m) : 0;
      e.chk_res = chk;
      e.lat = lat_ref(a, b, m, 1'b1);
      q1.push_back(e);
      e.lat = lat_ref(a, b, m, 1'b0);
      q0.push_back(e);
      @(posedge clk); #1;
      start = 1'b0;
      in_a  = W'($urandom_range(0, 255));
      in_b  = W'($urandom_range(0, 255));
      in_m  = W'($urandom_range(0, 255));
      if (intrude > 0) begin
         repeat (intrude) @(posedge clk);
         #1;
         in_a  = 8'd200;
         in_b  = 8'd100;
         in_m  = 8'd211;
         start = 1'b1;
         @(posedge clk); #1;
         start = 1'b0;
      end
   endtask

   initial begin
      int t;
      repeat (3) @(posedge clk);
      #1;
      check("reset busy1", int'(busy1), 0);
      check("reset done1", int'(done1), 0);
      check("reset result1", int'(res1), 0);
      check("reset busy0", int'(busy0), 0);
      check("reset done0", int'(done0), 0);
      check("reset result0", int'(res0), 0);
      resetn = 1'b1;
      @(posedge clk); #1;

      check("ref 5*7 mod 239", mont_ref(5, 7, 239), 227);
      run_job(5, 7, 239, 1, 0);
      run_job(0, 100, 239, 1, 0);
      run_job(17, 100, 239, 1, 0);
      run_job(77, 0, 239, 1, 0);
      run_job(238, 238, 239, 1, 0);
      run_job(5, 7, 239, 1, 5);
      run_job(100, 33, 240, 0, 0);

      run_job(123, 45, 251, 1, 0);
      repeat (9) @(posedge clk);
      #2;
      resetn = 1'b0;
      #1;
      check("abort busy1", int'(busy1), 0);
      check("abort done1", int'(done1), 0);
      check("abort result1", int'(res1), 0);
      check("abort busy0", int'(busy0), 0);
      check("abort done0", int'(done0), 0);
      check("abort result0", int'(res0), 0);
      q1.delete();
      q0.delete();
      @(posedge clk); #1;
      resetn = 1'b1;
      @(posedge clk); #1;
      run_job(123, 45, 251, 1, 0);

      for (int k = 0; k < 30; k++) begin
         int m = $urandom_range(1, 127) * 2 + 1;
         run_job($urandom_range(0, m - 1), $urandom_range(0, m - 1), m, 1, 0);
      end

      t = 0;
      while ((q1.size() != 0 || q0.size() != 0 || busy1 || busy0) && t < 500) begin
         @(posedge clk); #1;
         t++;
      end
      check("drain pending jobs", q1.size() + q0.size(), 0);
      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
      $fatal(1, "watchdog expired");
   end

endmodule
